mem_word_seq: RTL and testbench
===============================

# mem_word_seq

Word-level initiator for the bit-serial memory system. Accepts one read or write command per transaction on a valid/ready port, then drives the memory's single-bit interface (read/write request, bit address, bank select, write bit) for WORD_W consecutive bit addresses. Read bits are assembled into a word and returned on a valid/ready response port. One instance per memory side: ADDR_W=20 for the weight banks, ADDR_W=10 for the activation banks.

## Interface
Parameters:
- WORD_W, 16, bits per word transaction (≥2)
- ADDR_W, 20, bit-address width of the attached memory
- BANK_W, 2, bank-select width (four banks)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_bank  in  BANK_W  target bank
- cmd_addr  in  ADDR_W  bit address of word LSB
- cmd_wdata  in  WORD_W  write word; bit 0 goes to cmd_addr
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  WORD_W  read word (all zeros for write responses)
- rsp_write  out  1  echoes cmd_write of the completed transaction
- mem_read_rq  out  1  memory read request
- mem_write_rq  out  1  memory write request
- mem_addr  out  ADDR_W  memory bit address
- mem_wdata  out  1  memory write bit
- mem_sel  out  BANK_W  memory bank select
- mem_rdata  in  1  memory read bit, combinational from memory, valid in the same cycle as a read request

## Operation
- FSM states: IDLE, XFER, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch write flag, bank, address, and wdata. Clear the bit counter and go to XFER.
- XFER: cmd_ready=0. Each cycle, for bit index k (0..WORD_W-1):
  - mem_addr = latched addr + k, modulo 2^ADDR_W, so addresses wrap past the top.
  - mem_sel = latched bank.
  - Write: mem_write_rq=1, mem_read_rq=0, mem_wdata = wdata[k].
  - Read: mem_read_rq=1, mem_write_rq=0, mem_wdata=0. At the closing edge, mem_rdata is stored into rdata[k].
  - At k = WORD_W-1, go to RESP.
- RESP: rsp_valid=1, and rsp_rdata/rsp_write stay stable until rsp_ready is seen. Then go to IDLE.
- A new command is never accepted in the same cycle as a response handshake.
- mem_read_rq and mem_write_rq are never high together.
- Outside XFER: both requests are 0, and mem_addr, mem_wdata, mem_sel hold 0.
- Counter width is clog2(WORD_W). The counter does not run in IDLE or RESP.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_write=0, mem_read_rq=0, mem_write_rq=0, mem_addr=0, mem_wdata=0, mem_sel=0. FSM resets to IDLE.
- All outputs are registered, except cmd_ready, which decodes directly from state.
- Cycle timing, with command accepted at edge E0:
  - mem_* drive bit k during the cycle after edge E0+k, for k = 0..WORD_W-1.
  - rsp_valid rises after edge E0+WORD_W.
  - Read latency is WORD_W+1 cycles from acceptance to rsp_valid.
- Writes: the memory commits bit k at edge E0+k+1.
- Throughput: WORD_W+2 cycles per transaction when rsp_ready is held high.
- Reset mid-XFER aborts immediately and all outputs return to reset values. Bits already committed by a partial write remain in memory. No response is produced.
- rsp_ready low in RESP stalls indefinitely. No command is accepted while stalled.
- Address wrap: a command at 2^ADDR_W-3 with WORD_W=16 touches 2^ADDR_W-3 .. 2^ADDR_W-1, then 0..12.

## Structure
- Shared package `mem_seq_pkg`:
  - state enum {IDLE, XFER, RESP}
  - default WORD_W
  - bank-width constant BANK_W=2, shared with the memory system's select demux
- The top FSM owns the command/response registers.
- One natural sub-module, `mem_bit_serdes`, holds the bit counter, the write-word shift-out, and the read-word shift-in. Its done pulse fires at the last bit.

## Test plan
- Write then read, bank 1, addr 0x00100, wdata 0xA5C3 → write rsp_valid after 17 cycles with rsp_rdata=0. Read returns rsp_rdata=0xA5C3, and bank 0/2/3 at 0x00100 read 0x0000.
- Address wrap: write 0xFFFF at addr 0xFFFFD (ADDR_W=20) → read at 0xFFFFD returns 0xFFFF. A read at 0x00000 returns 0x1FFF in bits 12:0, i.e. 0x1FFF.
- Response backpressure: hold rsp_ready=0 for 10 cycles after a read → rsp_valid and rsp_rdata stay stable, cmd_ready=0, and no mem request is asserted during the stall.
- Reset mid-write: assert rst after bit 5 of a 0xFFFF write to cleared memory. Outputs return to reset values the same cycle. Because the memory also resets, a subsequent read returns 0x0000.
- Back-to-back commands with cmd_valid always high and rsp_ready=1 → transactions complete every 18 cycles. mem_read_rq and mem_write_rq are never simultaneously high, checked by assertion.
- ADDR_W=10 instance on activation memory: write 0x0001 at 0x3F8, read back 0x0001, with mem_addr sequence 0x3F8..0x3FF, 0x000..0x007.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared types and widths for the word-level memory sequencer
package mem_seq_pkg;
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
  localparam int DEF_WORD_W = 16;
  localparam int SEL_W = 2;
endpackage

// File: rtl/mem_bit_serdes.sv
// mem_bit_serdes: bit counter, write-word shift-out and read-word shift-in
module mem_bit_serdes #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_write,
  input  logic [WORD_W-1:0] load_word,
  input  logic              step,
  input  logic              mem_rdata,
  output logic              wbit,
  output logic              done,
  output logic [WORD_W-1:0] rword
);
  localparam int CW = $clog2(WORD_W);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] wsh_q, wsh_d, rsh_q, rsh_d;
  logic wbit_q, wbit_d;
  assign done = step && cnt_q == CW'(WORD_W - 1);
  // rword is the completed word once the last bit is on mem_rdata
  assign rword = {mem_rdata, rsh_q[WORD_W-1:1]};
  assign wbit = wbit_q;
  always_comb begin
    cnt_d = cnt_q;
    wsh_d = wsh_q;
    rsh_d = rsh_q;
    wbit_d = wbit_q;
    if (load) begin
      cnt_d = '0;
      wsh_d = load_write ? load_word >> 1 : '0;
      wbit_d = load_write & load_word[0];
    end else if (step) begin
      cnt_d = done ? '0 : cnt_q + CW'(1);
      wsh_d = wsh_q >> 1;
      rsh_d = rword;
      wbit_d = !done & wsh_q[0];
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q <= '0;
      wsh_q <= '0;
      rsh_q <= '0;
      wbit_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wsh_q <= wsh_d;
      rsh_q <= rsh_d;
      wbit_q <= wbit_d;
    end
endmodule

// File: rtl/mem_word_seq.sv
// mem_word_seq: word read/write initiator driving a bit-serial memory port
module mem_word_seq
  import mem_seq_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int ADDR_W = 20,
  parameter int BANK_W = SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [BANK_W-1:0] cmd_bank,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [WORD_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_write,
  output logic              mem_read_rq,
  output logic              mem_write_rq,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wdata,
  output logic [BANK_W-1:0] mem_sel,
  input  logic              mem_rdata
);
  state_t state_q, state_d;
  logic rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BANK_W-1:0] sel_q, sel_d;
  logic accept, step, done;
  logic [WORD_W-1:0] rword;
  assign cmd_ready = state_q == IDLE;
  assign accept = cmd_ready && cmd_valid;
  assign step = state_q == XFER;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_read_rq = rd_q;
  assign mem_write_rq = wr_q;
  assign mem_addr = addr_q;
  assign mem_sel = sel_q;
  mem_bit_serdes #(.WORD_W(WORD_W)) u_serdes (
    .clk, .rst, .load(accept), .load_write(cmd_write), .load_word(cmd_wdata),
    .step, .mem_rdata, .wbit(mem_wdata), .done, .rword
  );
  // mem_* registers carry the latched command during XFER and are zero elsewhere
  always_comb begin
    state_d = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rd_d = rd_q;
    wr_d = wr_q;
    addr_d = addr_q;
    sel_d = sel_q;
    if (accept) begin
      state_d = XFER;
      rd_d = !cmd_write;
      wr_d = cmd_write;
      addr_d = cmd_addr;
      sel_d = cmd_bank;
    end else if (done) begin
      state_d = RESP;
      rd_d = 1'b0;
      wr_d = 1'b0;
      addr_d = '0;
      sel_d = '0;
      rsp_valid_d = 1'b1;
      rsp_write_d = wr_q;
      rsp_rdata_d = rd_q ? rword : '0;
    end else if (step) begin
      addr_d = addr_q + ADDR_W'(1);
    end else if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
      rsp_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      sel_q <= '0;
    end else begin
      state_q <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      sel_q <= sel_d;
    end
endmodule

// File: tb/tb_mem_word_seq.sv
// tb_mem_word_seq: vectors, random traffic and corner sequences for mem_word_seq
module tb_mem_word_seq;
  logic clk, rst;
  logic cmd_valid, cmd_write, rsp_ready;
  logic [1:0] cmd_bank;
  logic [19:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic a_cmd_ready, a_rsp_valid, a_rsp_write, a_rq_r, a_rq_w, a_wd, a_rd;
  logic [15:0] a_rsp_rdata;
  logic [19:0] a_addr;
  logic [1:0] a_sel;
  logic b_cmd_ready, b_rsp_valid, b_rsp_write, b_rq_r, b_rq_w, b_wd, b_rd;
  logic [15:0] b_rsp_rdata;
  logic [9:0] b_addr;
  logic [1:0] b_sel;
  int checks = 0, failures = 0;
  bit sel_b = 0;
  bit mem_a[int], mem_b[int], ref_a[int], ref_b[int];
  logic o_cmd_ready, o_rsp_valid, o_rsp_write, o_rq_r, o_rq_w, o_wd;
  logic [15:0] o_rsp_rdata;
  logic [19:0] o_addr;
  logic [1:0] o_sel;

  mem_word_seq #(.WORD_W(16), .ADDR_W(20), .BANK_W(2)) dut_a (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(cmd_write),
    .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(a_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_write(a_rsp_write), .mem_read_rq(a_rq_r),
    .mem_write_rq(a_rq_w), .mem_addr(a_addr), .mem_wdata(a_wd), .mem_sel(a_sel), .mem_rdata(a_rd));
  mem_word_seq #(.WORD_W(16), .ADDR_W(10), .BANK_W(2)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(cmd_write),
    .cmd_bank(cmd_bank), .cmd_addr(cmd_addr[9:0]), .cmd_wdata(cmd_wdata), .rsp_valid(b_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_write(b_rsp_write), .mem_read_rq(b_rq_r),
    .mem_write_rq(b_rq_w), .mem_addr(b_addr), .mem_wdata(b_wd), .mem_sel(b_sel), .mem_rdata(b_rd));

  always_comb begin
    o_cmd_ready = sel_b ? b_cmd_ready : a_cmd_ready;
    o_rsp_valid = sel_b ? b_rsp_valid : a_rsp_valid;
    o_rsp_write = sel_b ? b_rsp_write : a_rsp_write;
    o_rsp_rdata = sel_b ? b_rsp_rdata : a_rsp_rdata;
    o_rq_r = sel_b ? b_rq_r : a_rq_r;
    o_rq_w = sel_b ? b_rq_w : a_rq_w;
    o_wd = sel_b ? b_wd : a_wd;
    o_addr = sel_b ? {10'b0, b_addr} : a_addr;
    o_sel = sel_b ? b_sel : a_sel;
  end

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // bit-serial memories: commit on the clock edge, read data settles by the falling edge
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      mem_a.delete();
      mem_b.delete();
    end else begin
      if (a_rq_w) mem_a[int'(a_sel) * 1048576 + int'(a_addr)] = a_wd;
      if (b_rq_w) mem_b[int'(b_sel) * 1024 + int'(b_addr)] = b_wd;
    end
  end
  initial begin
    a_rd = 0;
    b_rd = 0;
    forever begin
      @(negedge clk);
      a_rd = a_rq_r && mem_a.exists(int'(a_sel) * 1048576 + int'(a_addr)) ? mem_a[int'(a_sel) * 1048576 + int'(a_addr)] : 1'b0;
      b_rd = b_rq_r && mem_b.exists(int'(b_sel) * 1024 + int'(b_addr)) ? mem_b[int'(b_sel) * 1024 + int'(b_addr)] : 1'b0;
    end
  end

  always @(posedge clk) if (rst) begin
    assert (!(a_rq_r && a_rq_w));
    assert (!(b_rq_r && b_rq_w));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_read(input bit inst, input logic [1:0] bank, input logic [19:0] addr);
    int span = inst ? 1024 : 1048576;
    logic [15:0] w = '0;
    for (int k = 0; k < 16; k++) begin
      int key = int'(bank) * span + (int'(addr) + k) % span;
      w[k] = inst ? (ref_b.exists(key) ? ref_b[key] : 1'b0) : (ref_a.exists(key) ? ref_a[key] : 1'b0);
    end
    return w;
  endfunction

  function automatic void ref_write(input logic [1:0] bank, input logic [19:0] addr, input logic [15:0] wdata);
    for (int k = 0; k < 16; k++) begin
      ref_a[int'(bank) * 1048576 + (int'(addr) + k) % 1048576] = wdata[k];
      ref_b[int'(bank) * 1024 + (int'(addr) + k) % 1024] = wdata[k];
    end
  endfunction

  task automatic chk_rst(input string name);
    chk({name, "_a"}, {a_cmd_ready, a_rsp_valid, a_rsp_rdata, a_rsp_write, a_rq_r, a_rq_w, a_addr, a_wd, a_sel}, {1'b1, 43'b0});
    chk({name, "_b"}, {b_cmd_ready, b_rsp_valid, b_rsp_rdata, b_rsp_write, b_rq_r, b_rq_w, b_addr, b_wd, b_sel}, {1'b1, 33'b0});
  endtask

  task automatic txn(input bit inst, input bit wr, input logic [1:0] bank, input logic [19:0] addr,
                     input logic [15:0] wdata, input int stall, output logic [15:0] rdata);
    logic [19:0] amask = inst ? 20'h003FF : 20'hFFFFF;
    logic [15:0] exp = wr ? 16'h0 : ref_read(inst, bank, addr);
    logic [19:0] ak;
    sel_b = inst;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_bank = bank; cmd_addr = addr; cmd_wdata = wdata;
    rsp_ready = stall == 0;
    chk("cmd_ready_idle", o_cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ak = 20'(addr + 20'(k)) & amask;
      chk("xfer_bit", {o_rq_r, o_rq_w, o_addr, o_sel, o_wd, o_cmd_ready, o_rsp_valid},
          {!wr, wr, ak, bank, wr & wdata[k], 2'b00});
    end
    @(negedge clk);
    chk("rsp", {o_rsp_valid, o_rsp_write, o_rsp_rdata, o_cmd_ready}, {1'b1, wr, exp, 1'b0});
    chk("mem_idle", {o_rq_r, o_rq_w, o_addr, o_sel, o_wd}, 0);
    rdata = o_rsp_rdata;
    cmd_valid = 1; cmd_write = 0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall", {o_rsp_valid, o_rsp_rdata, o_cmd_ready, o_rq_r, o_rq_w}, {1'b1, exp, 3'b000});
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("after_hs", {o_cmd_ready, o_rsp_valid, o_rq_r, o_rq_w}, 4'b1000);
    cmd_valid = 0;
    if (wr) ref_write(bank, addr, wdata);
  endtask

  typedef struct {bit inst; bit wr; logic [1:0] bank; logic [19:0] addr; logic [15:0] wdata; logic [15:0] exp;} vec_t;
  vec_t vecs[12];

  initial begin
    logic [15:0] rd;
    int t, last, n;
    vecs[0]  = '{0, 1, 2'd1, 20'h00100, 16'hA5C3, 16'h0000};
    vecs[1]  = '{0, 0, 2'd1, 20'h00100, 16'h0000, 16'hA5C3};
    vecs[2]  = '{0, 0, 2'd0, 20'h00100, 16'h0000, 16'h0000};
    vecs[3]  = '{0, 0, 2'd2, 20'h00100, 16'h0000, 16'h0000};
    vecs[4]  = '{0, 0, 2'd3, 20'h00100, 16'h0000, 16'h0000};
    vecs[5]  = '{0, 1, 2'd2, 20'hFFFFD, 16'hFFFF, 16'h0000};
    vecs[6]  = '{0, 0, 2'd2, 20'hFFFFD, 16'h0000, 16'hFFFF};
    vecs[7]  = '{0, 0, 2'd2, 20'h00000, 16'h0000, 16'h1FFF};
    vecs[8]  = '{0, 0, 2'd2, 20'hFFFF8, 16'h0000, 16'hFFE0};
    vecs[9]  = '{1, 1, 2'd0, 20'h003F8, 16'h0001, 16'h0000};
    vecs[10] = '{1, 0, 2'd0, 20'h003F8, 16'h0000, 16'h0001};
    vecs[11] = '{1, 0, 2'd0, 20'h00000, 16'h0000, 16'h0000};
    rst = 0; cmd_valid = 0; cmd_write = 0; cmd_bank = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 1;
    repeat (3) @(negedge clk);
    chk_rst("reset");
    rst = 1;
    @(negedge clk);
    chk_rst("post_reset");
    for (int i = 0; i < 12; i++) begin
      txn(vecs[i].inst, vecs[i].wr, vecs[i].bank, vecs[i].addr, vecs[i].wdata, 0, rd);
      chk("vec", rd, vecs[i].exp);
    end
    txn(0, 0, 2'd1, 20'h00100, 16'h0, 10, rd);
    chk("backpressure_read", rd, 16'hA5C3);
    for (int i = 0; i < 40; i++) begin
      int off = $urandom_range(0, 40);
      logic [19:0] ra = $urandom_range(0, 1) ? 20'(1048575 - off) : 20'(off);
      txn(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, 16'($urandom), $urandom_range(0, 2), rd);
    end
    sel_b = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_bank = 1; cmd_addr = 20'h00100; rsp_ready = 1;
    t = 0; last = -1; n = 0;
    while (n < 4 && t < 200) begin
      @(negedge clk);
      t++;
      if (a_rsp_valid) begin
        if (last >= 0) chk("b2b_period", t - last, 18);
        chk("b2b_rdata", a_rsp_rdata, ref_read(0, 2'd1, 20'h00100));
        last = t;
        n++;
        if (n == 4) cmd_valid = 0;
      end
    end
    chk("b2b_count", n, 4);
    cmd_valid = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    ref_a.delete();
    ref_b.delete();
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_bank = 0; cmd_addr = 20'h00200; cmd_wdata = 16'hFFFF;
    @(posedge clk);
    #1 cmd_valid = 0;
    repeat (6) @(negedge clk);
    chk("mid_write_addr", a_addr, 20'h00205);
    @(posedge clk);
    #2 rst = 0;
    #1 chk_rst("mid_reset");
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk_rst("after_abort");
    txn(0, 0, 2'd0, 20'h00200, 16'h0, 0, rd);
    chk("abort_read", rd, 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
